// File: rtl/stoch_signed_decode_mat.sv
// Signed stochastic matrix decoder: integrates (X_p - X_m) per element over
// 2^WINDOW_LOG2 accepted samples and emits a registered signed count matrix.
module stoch_signed_decode_mat #(
  parameter int NUM_ROWS    = 2,
  parameter int NUM_COLS    = 2,
  parameter int WINDOW_LOG2 = 8,
  localparam int ACC_W      = WINDOW_LOG2 + 2
) (
  input  logic                                          CLK,
  input  logic                                          nRST,
  input  logic                                          start,
  input  logic                                          en,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]             X_p,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]             X_m,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][ACC_W-1:0]  Y,
  output logic                                          valid,
  output logic                                          busy
);

  // Handshake: a sample is consumed on every edge with busy=1, en=1, start=0.
  // valid is a one-cycle pulse meaning Y changed at the previous edge.

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  localparam logic signed [ACC_W-1:0] ONE = ACC_W'(1);

  state_t                                         state_q, state_d;
  logic [WINDOW_LOG2-1:0]                         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]                        acc_q [NUM_ROWS][NUM_COLS];
  logic signed [ACC_W-1:0]                        acc_d [NUM_ROWS][NUM_COLS];
  logic signed [ACC_W-1:0]                        sum   [NUM_ROWS][NUM_COLS];
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][ACC_W-1:0]   y_q, y_d;
  logic                                           valid_q, valid_d;
  logic                                           busy_q, busy_d;
  logic                                           last_sample;
  logic                                           accept;

  assign last_sample = (cnt_q == {WINDOW_LOG2{1'b1}});
  assign accept      = (state_q == S_ACCUM) && en && !start;

  // Per-element accumulator plus the current sample's contribution.
  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        sum[r][c] = acc_q[r][c];
        case ({X_p[r][c], X_m[r][c]})
          2'b10:   sum[r][c] = acc_q[r][c] + ONE;
          2'b01:   sum[r][c] = acc_q[r][c] - ONE;
          default: sum[r][c] = acc_q[r][c];
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    y_d     = y_q;
    valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          cnt_d   = '0;
          for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < NUM_COLS; c++)
              acc_d[r][c] = '0;
        end
      end
      S_ACCUM: begin
        if (start) begin
          // Restart: drop the partial window and the sample on this edge.
          cnt_d = '0;
          for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < NUM_COLS; c++)
              acc_d[r][c] = '0;
        end else if (accept) begin
          if (last_sample) begin
            state_d = S_IDLE;
            valid_d = 1'b1;
            cnt_d   = '0;
            for (int r = 0; r < NUM_ROWS; r++) begin
              for (int c = 0; c < NUM_COLS; c++) begin
                y_d[r][c]   = sum[r][c];
                acc_d[r][c] = '0;
              end
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            acc_d = sum;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_ACCUM);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++)
        for (int c = 0; c < NUM_COLS; c++)
          acc_q[r][c] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      acc_q   <= acc_d;
    end
  end

  assign Y     = y_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_stoch_signed_decode_mat.sv
// Directed bench for stoch_signed_decode_mat: a W=2 and a W=3 instance,
// each with an expected-Y queue drained by its own valid monitor.
module tb_stoch_signed_decode_mat;

  logic clk;
  logic nRST;

  // W=2 instance (ACC_W=4)
  logic                        start_a, en_a;
  logic [1:0][1:0]             xp_a, xm_a;
  logic [1:0][1:0][3:0]        y_a;
  logic                        valid_a, busy_a;

  // W=3 instance (ACC_W=5)
  logic                        start_b, en_b;
  logic [1:0][1:0]             xp_b, xm_b;
  logic [1:0][1:0][4:0]        y_b;
  logic                        valid_b, busy_b;

  logic [15:0] exp_q_a[$];
  logic [19:0] exp_q_b[$];

  int total = 0;
  int bad   = 0;

  stoch_signed_decode_mat #(.NUM_ROWS(2), .NUM_COLS(2), .WINDOW_LOG2(2)) u_dut_a (
    .CLK(clk), .nRST(nRST), .start(start_a), .en(en_a),
    .X_p(xp_a), .X_m(xm_a), .Y(y_a), .valid(valid_a), .busy(busy_a)
  );

  stoch_signed_decode_mat #(.NUM_ROWS(2), .NUM_COLS(2), .WINDOW_LOG2(3)) u_dut_b (
    .CLK(clk), .nRST(nRST), .start(start_b), .en(en_b),
    .X_p(xp_b), .X_m(xm_b), .Y(y_b), .valid(valid_b), .busy(busy_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: act=0x%0h req=0x%0h", name, act, req);
    end
  endtask

  // driver tasks: one call = one clock cycle, inputs applied at negedge
  task automatic drive_a(input logic s, input logic e, input logic [3:0] xp, input logic [3:0] xm);
    @(negedge clk);
    start_a = s; en_a = e; xp_a = xp; xm_a = xm;
  endtask

  task automatic drive_b(input logic s, input logic e, input logic [3:0] xp, input logic [3:0] xm);
    @(negedge clk);
    start_b = s; en_b = e; xp_b = xp; xm_b = xm;
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (nRST && valid_a === 1'b1) begin
      if (exp_q_a.size() == 0) begin
        chk("a_unexpected_valid", 32'(valid_a), 32'd0);
      end else begin
        chk("a_y_window", 32'(y_a), 32'(exp_q_a.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (nRST && valid_b === 1'b1) begin
      if (exp_q_b.size() == 0) begin
        chk("b_unexpected_valid", 32'(valid_b), 32'd0);
      end else begin
        chk("b_y_window", 32'(y_b), 32'(exp_q_b.pop_front()));
      end
    end
  end

  initial begin
    nRST = 1'b0;
    start_a = 0; en_a = 0; xp_a = '0; xm_a = '0;
    start_b = 0; en_b = 0; xp_b = '0; xm_b = '0;

    // reset held with random X
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      drive_b(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      chk("rst_y_a", 32'(y_a), 32'd0);
      chk("rst_valid_a", 32'(valid_a), 32'd0);
      chk("rst_busy_a", 32'(busy_a), 32'd0);
      chk("rst_y_b", 32'(y_b), 32'd0);
    end
    @(negedge clk);
    nRST = 1'b1;

    // no start for 10 cycles: random X ignored in IDLE
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      chk("idle_valid_a", 32'(valid_a), 32'd0);
      chk("idle_y_a", 32'(y_a), 32'd0);
    end
    drive_a(0, 0, 4'h0, 4'h0);

    // all +1 window -> every element +4
    drive_a(1, 0, 4'h0, 4'h0);
    drive_a(0, 1, 4'hF, 4'h0);
    chk("a1_busy_after_start", 32'(busy_a), 32'd1);
    drive_a(0, 1, 4'hF, 4'h0);
    drive_a(0, 1, 4'hF, 4'h0);
    chk("a1_no_early_valid", 32'(valid_a), 32'd0);
    exp_q_a.push_back(16'h4444);
    drive_a(0, 1, 4'hF, 4'h0);
    drive_a(0, 0, 4'h0, 4'h0);
    chk("a1_valid_next_cycle", 32'(valid_a), 32'd1);
    chk("a1_busy_drop", 32'(busy_a), 32'd0);
    drive_a(0, 0, 4'h0, 4'h0);
    chk("a1_valid_one_cycle", 32'(valid_a), 32'd0);
    chk("a1_y_hold", 32'(y_a), 32'h4444);

    // mixed: [0][0]=+1,-1,0,-1 -> -1; [0][1] all -1 -> -4; [1][0] (1,1) -> 0
    drive_a(1, 0, 4'h0, 4'h0);
    drive_a(0, 1, 4'b0101, 4'b0110);
    drive_a(0, 1, 4'b0100, 4'b0111);
    drive_a(0, 1, 4'b0101, 4'b0111);
    exp_q_a.push_back(16'h00CF);
    drive_a(0, 1, 4'b0100, 4'b0111);

    // start while valid is high, then abort on what would be the final sample
    drive_a(1, 0, 4'h0, 4'h0);
    chk("a2_valid_at_start", 32'(valid_a), 32'd1);
    chk("a2_y", 32'(y_a), 32'h00CF);
    drive_a(0, 1, 4'hF, 4'h0);
    chk("a3_valid_dropped", 32'(valid_a), 32'd0);
    chk("a3_busy", 32'(busy_a), 32'd1);
    drive_a(0, 1, 4'hF, 4'h0);
    drive_a(0, 1, 4'hF, 4'h0);
    drive_a(1, 1, 4'hF, 4'h0);
    drive_a(0, 1, 4'h0, 4'hF);
    chk("a3_abort_no_valid", 32'(valid_a), 32'd0);
    chk("a3_abort_busy", 32'(busy_a), 32'd1);
    chk("a3_y_retained", 32'(y_a), 32'h00CF);
    drive_a(0, 1, 4'h0, 4'hF);
    drive_a(0, 1, 4'h0, 4'hF);
    chk("a3_y_retained2", 32'(y_a), 32'h00CF);
    exp_q_a.push_back(16'hCCCC);
    drive_a(0, 1, 4'h0, 4'hF);
    drive_a(0, 0, 4'h0, 4'h0);
    drive_a(0, 0, 4'h0, 4'h0);

    // asynchronous reset mid-window
    drive_a(1, 0, 4'h0, 4'h0);
    drive_a(0, 1, 4'hF, 4'h0);
    drive_a(0, 1, 4'hF, 4'h0);
    @(negedge clk);
    start_a = 0; en_a = 0;
    #2 nRST = 1'b0;
    #1;
    chk("arst_y", 32'(y_a), 32'd0);
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_valid", 32'(valid_a), 32'd0);
    drive_a(0, 0, 4'h0, 4'h0);
    nRST = 1'b1;
    drive_a(1, 0, 4'h0, 4'h0);
    drive_a(0, 1, 4'hF, 4'h0);
    drive_a(0, 1, 4'hF, 4'h0);
    drive_a(0, 1, 4'hF, 4'h0);
    exp_q_a.push_back(16'h4444);
    drive_a(0, 1, 4'hF, 4'h0);
    drive_a(0, 0, 4'h0, 4'h0);
    drive_a(0, 0, 4'h0, 4'h0);

    // W=3 with en toggling: 8 accepted samples over 16 cycles -> +8
    drive_b(1, 0, 4'h0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      if (i == 14) exp_q_b.push_back({4{5'd8}});
      drive_b(0, (i % 2 == 0), 4'hF, 4'h0);
      if (i == 14) chk("b_busy_before_last", 32'(busy_b), 32'd1);
    end
    chk("b_busy_drop", 32'(busy_b), 32'd0);
    drive_b(0, 0, 4'h0, 4'h0);
    drive_b(0, 0, 4'h0, 4'h0);

    chk("a_queue_drained", 32'(exp_q_a.size()), 32'd0);
    chk("b_queue_drained", 32'(exp_q_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
